icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 5 +
 rtl/icache_array.sv | 40 ++++
 rtl/icache.sv | 101 ++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and defaults for the direct-mapped instruction cache.
package icache_pkg;
  localparam int IDX_W_DEF = 6;
  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;
endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, synchronous write; only valid bits reset.
module icache_array
  import icache_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);
  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     valid <= '0;
    else if (wr_en) valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];
endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-line instruction cache with single outstanding miss.
// Optional hit/miss counters when ICACHE_STAT_EN is defined.
module icache
  import icache_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic        if_rdy,
  output logic [31:0] if_inst,
  output logic        inst_miss,
  output logic [31:0] pc,
  input  logic        inst_rdy,
  input  logic [31:0] inst_out
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int TAG_W = 30 - IDX_W;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic        hit, wr_en, miss_start;
  logic        line_valid;
  logic [TAG_W-1:0] line_tag;
  logic [31:0] line_data;
  logic        unused_ok;

  assign unused_ok = ^{if_pc[1:0], pc[1:0]};

  icache_array #(.IDX_W(IDX_W)) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (if_pc[IDX_W+1:2]),
    .rd_valid(line_valid),
    .rd_tag  (line_tag),
    .rd_data (line_data),
    .wr_en   (wr_en & rdy),
    .wr_idx  (pc[IDX_W+1:2]),
    .wr_tag  (pc[31:IDX_W+2]),
    .wr_data (inst_out)
  );

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    wr_en      = 1'b0;
    miss_start = 1'b0;
    hit        = (state == IDLE) & if_valid & line_valid & (line_tag == if_pc[31:IDX_W+2]);
    if_rdy     = hit;
    if_inst    = hit ? line_data : 32'h0;
    // Dropped in the fill cycle so the controller never sees a second request.
    inst_miss  = (state == MISS) & ~inst_rdy & ~flush;
    case (state)
      IDLE: if (if_valid && !hit && !flush) begin
        miss_start = 1'b1;
        state_nxt  = MISS;
        pc_nxt     = if_pc;
      end
      MISS: begin
        // Fill data belongs to pc even if a flush lands in the same cycle.
        if (inst_rdy) begin
          wr_en     = 1'b1;
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= 32'h0;
    end else if (rdy) begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

`ifdef ICACHE_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else if (rdy) begin
      if (hit)        hit_cnt  <= hit_cnt + 32'd1;
      if (miss_start) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule
